spi_sram_responder: RTL and testbench

Synthesizable SPI target that behaves like the 23LC-series serial SRAM driven by `spi_master`. It decodes READ/WRITE/RDMR/WRMR commands and serves data from an internal byte array. It is the far end of the SRAM SPI bus, used for FPGA bring-up without the external SRAM and as the SRAM stand-in for the memory-subsystem bench. The system clock oversamples the SPI signals; `sclk` is treated as data, never as a clock.

---
 rtl/spi_sram_responder_pkg.sv | 7 +
 rtl/spi_sram_responder_sync_edge.sv | 23 ++
 rtl/spi_sram_responder.sv | 152 +++++++++++++++
 tb/tb_spi_sram_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_sram_responder_pkg.sv
// spi_sram_responder_pkg: SPI serial-SRAM opcodes shared by the initiator and the responder.
package spi_sram_responder_pkg;
    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
    localparam logic [7:0] SPI_CMD_RDMR  = 8'h05;
    localparam logic [7:0] SPI_CMD_WRMR  = 8'h01;
endpackage

// File: rtl/spi_sram_responder_sync_edge.sv
// sync_edge: 2-FF synchronizer for an asynchronous pin, with one-cycle rise/fall pulses
// taken from the synchronized level.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);
    // [0],[1] synchronizer stages, [2] previous synchronized level
    logic [2:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[1:0], d};

    always_ff @(posedge clk or posedge reset)
        if (reset) sync_q <= {3{RST_VAL}};
        else sync_q <= sync_d;

    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/spi_sram_responder.sv
// spi_sram_responder: oversampled SPI mode-0 target emulating a 23LC-style serial SRAM
// (READ/WRITE/RDMR/WRMR) backed by an internal byte array.
module spi_sram_responder
    import spi_sram_responder_pkg::*;
#(
    parameter int         DEPTH      = 4096,
    parameter logic [7:0] MODE_RESET = 8'h40
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    input  logic ce,
    input  logic si,
    output logic so,
    output logic so_oe,
    output logic active,
    output logic cmd_err,
    output logic wr_pulse
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [3:0] {
        IDLE, CMD, RD_ADDR, WR_ADDR, RD_DATA, WR_DATA, MODE_RD, MODE_WR, IGNORE
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    bit_q, bit_d;
    logic [6:0]    rx_q, rx_d;
    logic [7:0]    tx_q, tx_d, mode_q, mode_d, rd_q, byte_in, src;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    si_q, si_d;
    logic          so_q, so_d, oe_q, oe_d, err_q, err_d, wr_q, wr_d, we, bit_in;
    logic          sclk_rise, sclk_fall, ce_rise, ce_fall;
    logic [7:0]    mem [DEPTH];

    sync_edge #(.RST_VAL(1'b0)) u_sclk (
        .clk(clk), .reset(reset), .d(sclk), .rise(sclk_rise), .fall(sclk_fall)
    );

    // Resets low so a ce still held low when reset releases is not seen as a new selection
    sync_edge #(.RST_VAL(1'b0)) u_ce (
        .clk(clk), .reset(reset), .d(ce), .rise(ce_rise), .fall(ce_fall)
    );

    always_comb si_d = {si_q[0], si};

    assign bit_in  = si_q[1];
    assign byte_in = {rx_q, bit_in};
    assign src     = state_q == RD_DATA ? rd_q : mode_q;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        addr_d  = addr_q;
        mode_d  = mode_q;
        so_d    = so_q;
        oe_d    = oe_q;
        err_d   = 1'b0;
        wr_d    = 1'b0;
        we      = 1'b0;
        if (ce_rise) begin
            state_d = IDLE;
            so_d    = 1'b0;
            oe_d    = 1'b0;
        end else if (ce_fall) begin
            state_d = CMD;
            bit_d   = 5'd0;
            oe_d    = 1'b0;
        end else if (sclk_rise && state_q != IDLE) begin
            rx_d  = byte_in[6:0];
            bit_d = bit_q + 5'd1;
            case (state_q)
                CMD: if (bit_q == 5'd7) begin
                    bit_d   = 5'd0;
                    state_d = byte_in == SPI_CMD_READ  ? RD_ADDR :
                              byte_in == SPI_CMD_WRITE ? WR_ADDR :
                              byte_in == SPI_CMD_RDMR  ? MODE_RD :
                              byte_in == SPI_CMD_WRMR  ? MODE_WR : IGNORE;
                    err_d   = state_d == IGNORE;
                end
                // Upper address bits fall off the top of the shift register
                RD_ADDR, WR_ADDR: begin
                    addr_d = {addr_q[AW-2:0], bit_in};
                    if (bit_q == 5'd23) begin
                        bit_d   = 5'd0;
                        state_d = state_q == RD_ADDR ? RD_DATA : WR_DATA;
                    end
                end
                RD_DATA, MODE_RD: if (bit_q == 5'd7) begin
                    bit_d  = 5'd0;
                    addr_d = state_q == RD_DATA ? addr_q + AW'(1) : addr_q;
                end
                WR_DATA: if (bit_q == 5'd7) begin
                    bit_d  = 5'd0;
                    we     = 1'b1;
                    wr_d   = 1'b1;
                    addr_d = addr_q + AW'(1);
                end
                MODE_WR: if (bit_q == 5'd7) begin
                    mode_d  = byte_in;
                    state_d = IGNORE;
                end
                default: ;
            endcase
        end else if (sclk_fall && (state_q == RD_DATA || state_q == MODE_RD)) begin
            // A zero bit count marks a byte boundary: present a freshly fetched byte
            oe_d         = 1'b1;
            {so_d, tx_d} = bit_q == 5'd0 ? {src, 1'b0} : {tx_q, 1'b0};
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            addr_q  <= '0;
            mode_q  <= MODE_RESET;
            si_q    <= '0;
            so_q    <= 1'b0;
            oe_q    <= 1'b0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            si_q    <= si_d;
            so_q    <= so_d;
            oe_q    <= oe_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
        end

    // Read port tracks the current address; sclk timing leaves it settled before each use
    always_ff @(posedge clk) begin
        if (we) mem[addr_q] <= byte_in;
        rd_q <= mem[addr_q];
    end

    assign so       = so_q;
    assign so_oe    = oe_q;
    assign active   = state_q != IDLE;
    assign cmd_err  = err_q;
    assign wr_pulse = wr_q;
endmodule

// File: tb/tb_spi_sram_responder.sv
// tb_spi_sram_responder: randomized and directed SPI SRAM traffic against a byte-array model,
// read data checked by a scoreboard monitor on the so line.
module tb_spi_sram_responder;
    localparam int DEPTH = 4096;

    logic clk = 1'b0, reset = 1'b1, sclk = 1'b0, ce = 1'b1, si = 1'b0;
    logic so, so_oe, active, cmd_err, wr_pulse;

    int         n_tests = 0, n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mem_m [DEPTH];
    bit         mem_v [DEPTH];
    int         wr_cnt = 0, err_cnt = 0, oe_cyc = 0;
    int         nb = 0;
    logic [7:0] rx = 8'h00;
    int         lens [3] = '{1, 2, 4};
    logic [23:0] written[$];

    spi_sram_responder #(.DEPTH(DEPTH), .MODE_RESET(8'h40)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .ce(ce), .si(si),
        .so(so), .so_oe(so_oe), .active(active), .cmd_err(cmd_err), .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard: the initiator samples so on each rising sclk while the target drives it
    always @(posedge sclk or posedge ce or posedge reset)
        if (ce || reset) nb = 0;
        else if (so_oe) begin
            rx = {rx[6:0], so};
            nb++;
            if (nb == 8) begin
                nb = 0;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rd_extra: got %0h want no byte", rx);
                end else chk("rd_byte", rx, exp_q.pop_front());
            end
        end

    always @(negedge clk) begin
        if (wr_pulse) wr_cnt++;
        if (cmd_err) err_cnt++;
        if (so_oe) oe_cyc++;
    end

    task automatic half();
        repeat (5) @(negedge clk);
    endtask

    task automatic bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            si = b[i];
            half();
            sclk = 1'b1;
            half();
            sclk = 1'b0;
        end
    endtask

    task automatic select(input logic [7:0] cmd);
        ce = 1'b0;
        half();
        bits(cmd, 8);
    endtask

    task automatic addr24(input logic [23:0] a);
        bits(a[23:16], 8);
        bits(a[15:8], 8);
        bits(a[7:0], 8);
    endtask

    task automatic deselect();
        half();
        ce = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_write(input logic [23:0] a, input logic [31:0] w, input int len);
        int w0 = wr_cnt;
        logic [7:0] b;
        select(8'h02);
        addr24(a);
        for (int i = 0; i < len; i++) begin
            b = w[31 - 8*i -: 8];
            bits(b, 8);
            mem_m[(int'(a) + i) % DEPTH] = b;
            mem_v[(int'(a) + i) % DEPTH] = 1'b1;
        end
        deselect();
        chk("wr_pulses", wr_cnt - w0, len);
    endtask

    task automatic spi_read(input logic [23:0] a, input int len);
        select(8'h03);
        addr24(a);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(mem_m[(int'(a) + i) % DEPTH]);
            bits(8'h00, 8);
        end
        deselect();
    endtask

    task automatic rdmr(input int n, input logic [7:0] v);
        select(8'h05);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(v);
            bits(8'h00, 8);
        end
        deselect();
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, w0, o0, l, n;
        logic [23:0] a, r;
        repeat (4) @(negedge clk);
        chk("reset_outs", {so, so_oe, active, cmd_err, wr_pulse}, 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("idle_outs", {so, so_oe, active, cmd_err, wr_pulse}, 0);

        rdmr(2, 8'h40);
        select(8'h01);
        bits(8'h00, 8);
        bits(8'hA5, 8);
        deselect();
        rdmr(1, 8'h00);

        spi_write(24'h000010, 32'hDEADBEEF, 4);
        spi_read(24'h000010, 4);
        spi_write(24'h000FFF, 32'h1122_0000, 2);
        spi_read(24'h000000, 1);
        spi_read(24'h000FFF, 2);
        spi_write(24'h801003, 32'h5A00_0000, 1);
        spi_read(24'h000003, 1);

        e0 = err_cnt; w0 = wr_cnt; o0 = oe_cyc;
        select(8'hFF);
        bits(8'h12, 8);
        bits(8'h34, 8);
        deselect();
        chk("bad_cmd_err", err_cnt - e0, 1);
        chk("bad_no_wr", wr_cnt - w0, 0);
        chk("bad_no_oe", oe_cyc - o0, 0);

        e0 = err_cnt;
        ce = 1'b0;
        half();
        bits(8'hFF, 5);
        deselect();
        chk("partial_op_no_err", err_cnt - e0, 0);

        spi_write(24'h000020, 32'h7700_0000, 1);
        w0 = wr_cnt;
        select(8'h02);
        addr24(24'h000020);
        bits(8'h88, 5);
        deselect();
        chk("abort_no_wr", wr_cnt - w0, 0);
        spi_read(24'h000020, 1);

        select(8'h03);
        addr24(24'h000010);
        bits(8'h00, 3);
        chk("pre_rst_oe", so_oe, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_oe", so_oe, 0);
        chk("rst_active", active, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        bits(8'h03, 8);
        bits(8'h00, 8);
        chk("post_rst_idle", {active, so_oe}, 0);
        deselect();
        spi_read(24'h000010, 4);
        rdmr(1, 8'h40);

        for (int k = 0; k < 16; k++) begin
            a = 24'($urandom_range(0, 24'hFFFFFF));
            spi_write(a, $urandom, lens[$urandom_range(0, 2)]);
            written.push_back(a);
            r = written[$urandom_range(0, written.size() - 1)];
            l = lens[$urandom_range(0, 2)];
            n = 0;
            while (n < l && mem_v[(int'(r) + n) % DEPTH]) n++;
            spi_read(r, n);
        end

        chk("exp_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
